spi_register_file: RTL
======================

// Module: spi_register_file
// PURPOSE
//  Command decoder and byte-wide register bank behind the SPI memory slave. Decodes
//  cmd/addr/write_data from the slave, drives its expect_* / insert_dummy_cycles
//  controls, and serves read_data. Registers feed camera control logic via regs_flat.
// PARAMETERS
//  ADDR_BYTES    3       width of slave addr bus in bytes (must match slave)
//  REG_ADDR_BITS 4       register bank = 2**REG_ADDR_BITS bytes; low addr bits used
//  DEVICE_ID     16'hCA01 returned by READ_ID, MSB first
// PORTS
//  main_clock            in  1   system clock; must be >= 4x SCK
//  reset                 in  1   asynchronous, active-high
//  cmd                   in  8   command byte from slave
//  cmd_valid             in  1   level; high once cmd is complete
//  addr                  in  ADDR_BYTES*8  address from slave
//  addr_valid            in  1   level; high once addr is complete
//  write_data            in  8   data byte from slave
//  write_data_valid      in  1   rising edge = new byte written
//  read_data_captured    in  1   rising edge = slave latched read_data
//  operation_in_progress in  1   high while CS asserted
//  expect_addr/expect_write/expect_read/insert_dummy_cycles  out 1 each  to slave
//  read_data             out 8   byte the slave shifts out next
//  regs_flat             out 8*2**REG_ADDR_BITS  register bank, reg0 in bits [7:0]
//  reg_write_strobe      out 1   one-cycle pulse per committed register write
// BEHAVIOUR
//  Reset: all outputs 0, regs 0, ptr 0, state IDLE, WEL 0.
//  Edge detect on cmd_valid, addr_valid, write_data_valid, read_data_captured (1 FF each).
//  States: IDLE -> (cmd_valid rise) DECODE -> WAIT_ADDR | DATA | NOP; any -> IDLE when
//   operation_in_progress low (abort mid-transaction; no partial byte written).
//  Commands: 0x02 WRITE: expect_addr=1; after addr_valid expect_write=1.
//   0x03 READ: expect_addr=1; after addr_valid expect_read=1, dummy=0.
//   0x0B FAST_READ: as 0x03 with insert_dummy_cycles=1.
//   0x9F READ_ID: expect_read=1 immediately; bytes DEVICE_ID[15:8], [7:0], then 0x00.
//   0x05 READ_STATUS: expect_read=1 immediately; byte {6'b0, WEL, 1'b0}, repeating.
//   other: all expect_* 0 (NOP; slave idles).
//  expect_write/expect_read never asserted before addr_valid for addressed commands.
//  Control outputs registered: 1 main_clock after the triggering input edge.
//  ptr <= addr[REG_ADDR_BITS-1:0] on addr_valid rise; read_data <= regs[ptr] same cycle+1.
//  Write: on write_data_valid rise regs[ptr]<=write_data, reg_write_strobe=1, ptr++.
//  Read: on read_data_captured rise ptr++, read_data refreshed next cycle (ID index++).
//  ptr wraps 2**REG_ADDR_BITS-1 -> 0. Address bits above REG_ADDR_BITS ignored.
//  Simultaneous write edge and CS release in same cycle: write commits, then IDLE.
// CONFIGURATION
//  SPI_REGFILE_WRITE_LATCH_EN defined: 0x06 WREN sets WEL, 0x04 WRDI clears it;
//   WRITE bytes discarded (no strobe, ptr still increments) when WEL=0; WEL cleared
//   when a WRITE transaction ends (CS high). Status bit1 reflects WEL.
//  Undefined: 0x06/0x04 are NOPs, writes always commit, status bit1 reads 0.
// TESTING
//  CS, cmd 0x02, addr 0x000003, data A5 5A -> regs[3]=A5, regs[4]=5A, 2 strobes.
//  CS, cmd 0x03, addr 0x00000F, read 2 bytes -> read_data reg15 then reg0 (wrap).
//  cmd 0x0B addr 0x000003 -> insert_dummy_cycles=1, first byte A5 after 8 dummy SCK.
//  cmd 0x9F read 3 bytes -> CA, 01, 00; cmd 0x55 -> all expect_* stay 0.
//  reset asserted mid WRITE after 4 data bits -> regs all 0, outputs 0, state IDLE.
//  WRITE_LATCH_EN: write w/o 0x06 -> regs unchanged, status 0x00; with 0x06 -> status
//   0x02, write commits, status 0x00 after CS release.

Source files
------------

// File: rtl/spi_register_file.sv
// spi_register_file: command decoder and byte-wide register bank behind the SPI
// memory slave. Decodes cmd/addr/write_data, steers the slave's expect_* and
// dummy-cycle controls, serves read_data and exposes the bank on regs_flat.
//
// Optional feature macro: SPI_REGFILE_WRITE_LATCH_EN
//   defined   -> WREN(0x06)/WRDI(0x04) control a write-enable latch (WEL); WRITE
//                bytes are discarded while WEL=0; WEL clears when a WRITE ends.
//   undefined -> 0x06/0x04 are NOPs, writes always commit, status bit1 reads 0.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | CS released or waiting for the command byte
// S_DECODE  | command byte captured, choosing the transaction type
// S_WAIT_ADDR | addressed command, waiting for the address to complete
// S_DATA    | data phase: register writes or read byte stream
// S_NOP     | unknown/no-data command, slave idles until CS release
module spi_register_file #(
  parameter int          ADDR_BYTES    = 3,
  parameter int          REG_ADDR_BITS = 4,
  parameter logic [15:0] DEVICE_ID     = 16'hCA01
) (
  input  logic                            main_clock,
  input  logic                            reset,
  input  logic [7:0]                      cmd,
  input  logic                            cmd_valid,
  input  logic [ADDR_BYTES*8-1:0]         addr,
  input  logic                            addr_valid,
  input  logic [7:0]                      write_data,
  input  logic                            write_data_valid,
  input  logic                            read_data_captured,
  input  logic                            operation_in_progress,
  output logic                            expect_addr,
  output logic                            expect_write,
  output logic                            expect_read,
  output logic                            insert_dummy_cycles,
  output logic [7:0]                      read_data,
  output logic [8*(2**REG_ADDR_BITS)-1:0] regs_flat,
  output logic                            reg_write_strobe
);

  localparam int NREG = 2**REG_ADDR_BITS;

  localparam logic [7:0] CMD_WRITE     = 8'h02;
  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_READ_ID   = 8'h9F;
  localparam logic [7:0] CMD_STATUS    = 8'h05;
`ifdef SPI_REGFILE_WRITE_LATCH_EN
  localparam logic [7:0] CMD_WREN      = 8'h06;
  localparam logic [7:0] CMD_WRDI      = 8'h04;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT_ADDR,
    S_DATA,
    S_NOP
  } state_t;

  state_t                   state, state_next;
  logic                     cmd_valid_q, addr_valid_q, wdv_q, rdc_q;
  logic                     cmd_rise, addr_rise, wdv_rise, rdc_rise;
  logic [7:0]               cmd_q;
  logic [7:0]               regs [NREG];
  logic [REG_ADDR_BITS-1:0] ptr;
  logic [1:0]               id_idx;
  logic                     wel;
  logic                     write_ok;
  logic [7:0]               rd_next;
  logic                     ea_n, ew_n, er_n, dm_n;
  logic                     cmd_is_read, cmd_q_is_read;

  assign cmd_rise  = cmd_valid & ~cmd_valid_q;
  assign addr_rise = addr_valid & ~addr_valid_q;
  assign wdv_rise  = write_data_valid & ~wdv_q;
  assign rdc_rise  = read_data_captured & ~rdc_q;

  assign cmd_is_read   = (cmd == CMD_READ) || (cmd == CMD_FAST_READ);
  assign cmd_q_is_read = (cmd_q == CMD_READ) || (cmd_q == CMD_FAST_READ);

`ifdef SPI_REGFILE_WRITE_LATCH_EN
  assign write_ok = wel;
`else
  assign write_ok = 1'b1;
`endif

  // One-flop history of each slave strobe for rising-edge detection
  always_ff @(posedge main_clock or posedge reset) begin
    if (reset) begin
      cmd_valid_q  <= 1'b0;
      addr_valid_q <= 1'b0;
      wdv_q        <= 1'b0;
      rdc_q        <= 1'b0;
    end else begin
      cmd_valid_q  <= cmd_valid;
      addr_valid_q <= addr_valid;
      wdv_q        <= write_data_valid;
      rdc_q        <= read_data_captured;
    end
  end

  // State register and registered slave controls
  always_ff @(posedge main_clock or posedge reset) begin
    if (reset) begin
      state               <= S_IDLE;
      expect_addr         <= 1'b0;
      expect_write        <= 1'b0;
      expect_read         <= 1'b0;
      insert_dummy_cycles <= 1'b0;
    end else begin
      state               <= state_next;
      expect_addr         <= ea_n;
      expect_write        <= ew_n;
      expect_read         <= er_n;
      insert_dummy_cycles <= dm_n;
    end
  end

  // Next state and next control values; CS release overrides everything
  always_comb begin
    state_next = state;
    ea_n       = expect_addr;
    ew_n       = expect_write;
    er_n       = expect_read;
    dm_n       = insert_dummy_cycles;
    case (state)
      S_IDLE: begin
        if (cmd_rise) begin
          state_next = S_DECODE;
          // Addressed commands only ask for the address here; data direction
          // is withheld until the address has arrived.
          if (cmd == CMD_WRITE || cmd_is_read) begin
            ea_n = 1'b1;
          end else if (cmd == CMD_READ_ID || cmd == CMD_STATUS) begin
            er_n = 1'b1;
          end
        end
      end
      S_DECODE: begin
        if (cmd_q == CMD_WRITE || cmd_q_is_read) begin
          state_next = S_WAIT_ADDR;
        end else if (cmd_q == CMD_READ_ID || cmd_q == CMD_STATUS) begin
          state_next = S_DATA;
        end else begin
          state_next = S_NOP;
        end
      end
      S_WAIT_ADDR: begin
        if (addr_rise) begin
          state_next = S_DATA;
          ea_n       = 1'b0;
          ew_n       = (cmd_q == CMD_WRITE);
          er_n       = cmd_q_is_read;
          dm_n       = (cmd_q == CMD_FAST_READ);
        end
      end
      default: ;
    endcase
    if (!operation_in_progress) begin
      state_next = S_IDLE;
      ea_n       = 1'b0;
      ew_n       = 1'b0;
      er_n       = 1'b0;
      dm_n       = 1'b0;
    end
  end

  // Byte presented to the slave for the current data phase
  always_comb begin
    rd_next = 8'h00;
    if (state == S_DATA) begin
      if (cmd_q_is_read) begin
        rd_next = regs[ptr];
      end else if (cmd_q == CMD_READ_ID) begin
        case (id_idx)
          2'd0:    rd_next = DEVICE_ID[15:8];
          2'd1:    rd_next = DEVICE_ID[7:0];
          default: rd_next = 8'h00;
        endcase
      end else if (cmd_q == CMD_STATUS) begin
        rd_next = {6'b0, wel, 1'b0};
      end
    end
  end

  // Register bank, pointer, ID index, WEL and read data
  always_ff @(posedge main_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
      ptr              <= '0;
      id_idx           <= 2'd0;
      wel              <= 1'b0;
      cmd_q            <= 8'h00;
      read_data        <= 8'h00;
      reg_write_strobe <= 1'b0;
    end else begin
      reg_write_strobe <= 1'b0;
      read_data        <= rd_next;
      case (state)
        S_IDLE: begin
          id_idx <= 2'd0;
          if (cmd_rise) cmd_q <= cmd;
        end
`ifdef SPI_REGFILE_WRITE_LATCH_EN
        S_DECODE: begin
          if (cmd_q == CMD_WREN) wel <= 1'b1;
          if (cmd_q == CMD_WRDI) wel <= 1'b0;
        end
`endif
        S_WAIT_ADDR: begin
          if (addr_rise) ptr <= addr[REG_ADDR_BITS-1:0];
        end
        S_DATA: begin
          // A write edge coinciding with CS release still commits.
          if (cmd_q == CMD_WRITE && wdv_rise) begin
            if (write_ok) begin
              regs[ptr]        <= write_data;
              reg_write_strobe <= 1'b1;
            end
            ptr <= ptr + 1'b1;
          end
          if (rdc_rise) begin
            if (cmd_q_is_read) ptr <= ptr + 1'b1;
            if (cmd_q == CMD_READ_ID && id_idx != 2'd2) id_idx <= id_idx + 2'd1;
          end
        end
        default: ;
      endcase
`ifdef SPI_REGFILE_WRITE_LATCH_EN
      if (state != S_IDLE && cmd_q == CMD_WRITE && !operation_in_progress) wel <= 1'b0;
`endif
    end
  end

  // Flatten the bank, reg0 in the low byte
  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NREG; i++) regs_flat[i*8 +: 8] = regs[i];
  end

endmodule
